// File: rtl/uart_msg_launcher.sv
// rtl/uart_msg_launcher.sv - serial message launcher: packed byte string to UART frames
//
// Purpose:
//   On an accepted REQ the whole MSG vector is latched. Leading zero bytes
//   (from the top byte down) are skipped one per clock. Each following
//   nonzero byte is then sent on TXD as an asynchronous serial frame:
//   start, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop
//   bits, and GAP_BITS idle bit-times. The first zero byte after the first
//   nonzero byte ends the message, and so does reaching MSG_BYTES characters.
//   Completion is signalled by a one-cycle DONE pulse.
//
// Ports:
//   CLK       in   bit/system clock, rising-edge
//   RESETn    in   asynchronous active-low reset
//   MSG       in   packed message, top byte sent first, sampled on acceptance
//   REQ       in   start request, level-sampled while idle
//   TXD       out  serial output, idle high
//   BUSY      out  high from acceptance until the DONE cycle
//   DONE      out  single-cycle completion pulse
//   TX_COUNT  out  characters sent in the current or last message

module uart_msg_launcher #(
   parameter int MSG_BYTES    = 128,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 1,
   parameter int GAP_BITS     = 0
) (
   input  logic                           CLK,
   input  logic                           RESETn,
   input  logic [MSG_BYTES*8-1:0]         MSG,
   input  logic                           REQ,
   output logic                           TXD,
   output logic                           BUSY,
   output logic                           DONE,
   output logic [$clog2(MSG_BYTES+1)-1:0] TX_COUNT
);

   localparam int MSG_W  = MSG_BYTES * 8;
   localparam int CNT_W  = $clog2(MSG_BYTES + 1);
   localparam int TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int SG_MAX = (STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS;
   localparam int SG_W   = (SG_MAX > 1) ? $clog2(SG_MAX) : 1;
   // Only the low DATA_BITS of a byte take part in the parity calculation.
   localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_GAP,
      S_FINISH
   } state_t;

   state_t             state_q, state_d;
   logic [MSG_W-1:0]   sh_q, sh_d;
   logic [CNT_W-1:0]   scan_q, scan_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [2:0]         bidx_q, bidx_d;
   logic [SG_W-1:0]    sg_q, sg_d;
   logic               txd_q, txd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [7:0]         top;
   logic [MSG_W-1:0]   sh_shift;
   logic               bit_end;
   logic               par_bit;
   logic               in_frame;
   logic               frame_end;

   assign top      = sh_q[MSG_W-1 -: 8];
   assign sh_shift = sh_q << 8;
   assign bit_end  = (tmr_q == TMR_W'(CLKS_PER_BIT - 1));
   assign par_bit  = (PARITY == 2) ? ~(^(top & DMASK)) : ^(top & DMASK);
   assign in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_PAR)   || (state_q == S_STOP) ||
                     (state_q == S_GAP);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         scan_q  <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         bidx_q  <= '0;
         sg_q    <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         scan_q  <= scan_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         bidx_q  <= bidx_d;
         sg_q    <= sg_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      scan_d    = scan_q;
      cnt_d     = cnt_q;
      tmr_d     = tmr_q;
      bidx_d    = bidx_q;
      sg_d      = sg_q;
      txd_d     = txd_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      frame_end = 1'b0;

      // The bit timer free-runs inside a frame and wraps at each bit-time
      // boundary, so it is always zero when a new frame starts.
      if (in_frame) begin
         tmr_d = bit_end ? '0 : tmr_q + TMR_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (REQ) begin
               sh_d    = MSG;
               busy_d  = 1'b1;
               cnt_d   = '0;
               scan_d  = '0;
               state_d = S_SCAN;
            end
         end

         S_SCAN: begin
            if (scan_q == CNT_W'(MSG_BYTES)) begin
               state_d = S_FINISH;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (top != 8'h00) begin
               state_d = S_START;
               txd_d   = 1'b0;
            end else begin
               sh_d   = sh_shift;
               scan_d = scan_q + CNT_W'(1);
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bidx_d  = '0;
               txd_d   = top[0];
            end
         end

         S_DATA: begin
            if (bit_end) begin
               if (bidx_q == 3'(DATA_BITS - 1)) begin
                  if (PARITY != 0) begin
                     state_d = S_PAR;
                     txd_d   = par_bit;
                  end else begin
                     state_d = S_STOP;
                     sg_d    = '0;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bidx_d = bidx_q + 3'd1;
                  txd_d  = top[bidx_q + 3'd1];
               end
            end
         end

         S_PAR: begin
            if (bit_end) begin
               state_d = S_STOP;
               sg_d    = '0;
               txd_d   = 1'b1;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               if (sg_q == SG_W'(STOP_BITS - 1)) begin
                  if (GAP_BITS != 0) begin
                     state_d = S_GAP;
                     sg_d    = '0;
                  end else begin
                     frame_end = 1'b1;
                  end
               end else begin
                  sg_d = sg_q + SG_W'(1);
               end
            end
         end

         S_GAP: begin
            if (bit_end) begin
               if (sg_q == SG_W'(GAP_BITS - 1)) begin
                  frame_end = 1'b1;
               end else begin
                  sg_d = sg_q + SG_W'(1);
               end
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Frame retired: count it, expose the next byte, and either start the
      // next frame on this very edge (back-to-back) or finish the message.
      if (frame_end) begin
         sh_d = sh_shift;
         if (cnt_q != CNT_W'(MSG_BYTES)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if ((sh_shift[MSG_W-1 -: 8] == 8'h00) || (cnt_d == CNT_W'(MSG_BYTES))) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
         end else begin
            state_d = S_START;
            txd_d   = 1'b0;
         end
      end
   end

   assign TXD      = txd_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign TX_COUNT = cnt_q;

endmodule
